// File: rtl/mrv32_mmio.sv
// Memory-mapped peripheral block for the mrv32 core: machine timer, console TX FIFO and halt port.
// Reads return through a fixed-latency pipeline; writes take effect in their request cycle.
module mrv32_mmio #(
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   output logic [31:0]           rdata,
   output logic                  rvalid,
   output logic                  timer_irq,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   input  logic                  tx_ready,
   output logic                  halt,
   output logic [7:0]            halt_code
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_TX_DATA     = 3'd4,
      REG_STATUS      = 3'd5,
      REG_HALT        = 3'd6,
      REG_UNMAPPED    = 3'd7
   } reg_sel_t;

   reg_sel_t         sel;
   logic             wr_en;
   logic             rd_en;
   logic             unused_addr;

   logic [63:0]      mtime;
   logic [63:0]      mtime_next;
   logic [63:0]      mtimecmp;
   logic [63:0]      mtimecmp_next;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             ovf;
   logic             ovf_set;
   logic             ovf_clr;

   logic [31:0]      status;
   logic [31:0]      read_mux;
   logic [31:0]      rd_data_pipe [RD_LATENCY];
   logic [RD_LATENCY-1:0] rd_valid_pipe;

   assign sel         = reg_sel_t'(addr[4:2]);
   assign wr_en       = valid && (wstrb != 4'd0);
   assign rd_en       = valid && (wstrb == 4'd0);
   assign unused_addr = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};

   assign timer_irq = (mtime >= mtimecmp);

   assign empty    = (count == '0);
   assign full     = (count == FULL_COUNT);
   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'd0 : fifo_mem[rd_ptr];
   assign pop      = tx_valid && tx_ready;
   assign push_req = wr_en && (sel == REG_TX_DATA) && wstrb[0];
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = wr_en && (sel == REG_STATUS) && wstrb[0] && wdata[4];

   assign status = {27'd0, ovf, full, empty, !empty, timer_irq};

   // Bytes written by software override the freshly incremented timer value.
   always_comb begin
      mtime_next    = mtime + 64'd1;
      mtimecmp_next = mtimecmp;
      for (int b = 0; b < 4; b++) begin
         if (wr_en && wstrb[b]) begin
            if (sel == REG_MTIME_LO)    mtime_next[8*b +: 8]       = wdata[8*b +: 8];
            if (sel == REG_MTIME_HI)    mtime_next[32+8*b +: 8]    = wdata[8*b +: 8];
            if (sel == REG_MTIMECMP_LO) mtimecmp_next[8*b +: 8]    = wdata[8*b +: 8];
            if (sel == REG_MTIMECMP_HI) mtimecmp_next[32+8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   // The timer reads back the value it holds once this cycle's write and tick have landed.
   always_comb begin
      read_mux = 32'd0;
      case (sel)
         REG_MTIME_LO:    read_mux = mtime_next[31:0];
         REG_MTIME_HI:    read_mux = mtime_next[63:32];
         REG_MTIMECMP_LO: read_mux = mtimecmp[31:0];
         REG_MTIMECMP_HI: read_mux = mtimecmp[63:32];
         REG_STATUS:      read_mux = status;
         default:         read_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime     <= 64'd0;
         mtimecmp  <= {64{1'b1}};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         halt      <= 1'b0;
         halt_code <= 8'd0;
      end else begin
         mtime    <= mtime_next;
         mtimecmp <= mtimecmp_next;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         if (wr_en && (sel == REG_HALT) && wstrb[0] && !halt) begin
            halt      <= 1'b1;
            halt_code <= wdata[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wdata[7:0];
   end

   // Reset flushes the read pipeline so no response survives across it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_pipe <= '0;
         for (int i = 0; i < RD_LATENCY; i++) rd_data_pipe[i] <= 32'd0;
      end else begin
         rd_valid_pipe[0] <= rd_en;
         rd_data_pipe[0]  <= rd_en ? read_mux : 32'd0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_valid_pipe[i] <= rd_valid_pipe[i-1];
            rd_data_pipe[i]  <= rd_data_pipe[i-1];
         end
      end
   end

   assign rvalid = rd_valid_pipe[RD_LATENCY-1];
   assign rdata  = rd_data_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_mrv32_mmio.sv
// Self-checking bench for mrv32_mmio: table-driven register vectors plus hand-written timer,
// FIFO, halt and reset sequences; read responses are matched against a scoreboard queue.
module tb_mrv32_mmio;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] addr = 16'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        timer_irq;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        halt;
   logic [7:0]  halt_code;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rv_seen = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      string       name;
   } rd_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   rd_exp_t     sbq[$];
   logic [7:0]  txq[$];
   vec_t        vecs[15];
   rd_exp_t     mon_e;

   mrv32_mmio #(.ADDR_WIDTH(16), .RD_LATENCY(RD_LAT), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .rvalid(rvalid), .timer_irq(timer_irq), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .halt(halt), .halt_code(halt_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic [31:0] e, input logic rdy, input bit track,
                                input string nm);
      rd_exp_t x;
      @(posedge clk); #1;
      valid    = 1'b1;
      addr     = a;
      wdata    = d;
      wstrb    = s;
      tx_ready = rdy;
      if (track && s == 4'd0) begin
         x.data = e;
         x.cyc  = cyc + RD_LAT;
         x.name = nm;
         sbq.push_back(x);
      end
   endtask

   task automatic applyIdle(input logic rdy);
      @(posedge clk); #1;
      valid    = 1'b0;
      wstrb    = 4'd0;
      tx_ready = rdy;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " rvalid"}, rvalid, 0);
      checkOutput({tag, " rdata"}, rdata, 0);
      checkOutput({tag, " timer_irq"}, timer_irq, 0);
      checkOutput({tag, " tx_valid"}, tx_valid, 0);
      checkOutput({tag, " tx_data"}, tx_data, 0);
      checkOutput({tag, " halt"}, halt, 0);
      checkOutput({tag, " halt_code"}, halt_code, 0);
   endtask

   // Read responses must arrive in order, exactly RD_LAT cycles after issue; TX bytes in push order.
   always @(negedge clk) begin
      if (rvalid) begin
         rv_seen++;
         if (sbq.size() == 0) begin
            checkOutput("unexpected rvalid", rvalid, 0);
         end else begin
            mon_e = sbq.pop_front();
            checkOutput({mon_e.name, " data"}, rdata, mon_e.data);
            checkOutput({mon_e.name, " cycle"}, cyc, mon_e.cyc);
         end
      end
      if (tx_valid && tx_ready) begin
         if (txq.size() == 0) checkOutput("unexpected tx byte", tx_valid, 0);
         else                 checkOutput("tx byte", tx_data, txq.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a_cyc;
      int rv_before;

      vecs[0]  = '{16'h0008, 32'h12345678, 4'b1111, 32'h0};
      vecs[1]  = '{16'h0008, 32'h0,        4'b0000, 32'h12345678};
      vecs[2]  = '{16'h000C, 32'hAABBCCDD, 4'b0011, 32'h0};
      vecs[3]  = '{16'h000C, 32'h0,        4'b0000, 32'hFFFFCCDD};
      vecs[4]  = '{16'h0010, 32'h0,        4'b0000, 32'h0};
      vecs[5]  = '{16'h001C, 32'h0,        4'b0000, 32'h0};
      vecs[6]  = '{16'h0018, 32'h0,        4'b0000, 32'h0};
      vecs[7]  = '{16'h001C, 32'hFFFFFFFF, 4'b1111, 32'h0};
      vecs[8]  = '{16'h0008, 32'h9A000000, 4'b1000, 32'h0};
      vecs[9]  = '{16'hFF0B, 32'h0,        4'b0000, 32'h9A345678};
      vecs[10] = '{16'h0014, 32'h0,        4'b0000, 32'h00000004};
      vecs[11] = '{16'h0010, 32'h0000FFFF, 4'b0010, 32'h0};
      vecs[12] = '{16'h0014, 32'h0,        4'b0000, 32'h00000004};
      vecs[13] = '{16'h0018, 32'h000000EE, 4'b0010, 32'h0};
      vecs[14] = '{16'h0004, 32'h0,        4'b0000, 32'h0};

      $display("[TB] reset with requests presented");
      for (int i = 0; i < 4; i++) applyStimulus(16'h0014, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, "in reset");
      checkResetOutputs("reset");
      applyIdle(1'b0);
      rst_n = 1'b1;
      applyIdle(1'b0);

      $display("[TB] STATUS read latency");
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000004, 1'b0, 1'b1, "status after reset");
      for (int i = 0; i < 4; i++) applyIdle(1'b0);

      $display("[TB] register vector table");
      for (int i = 0; i < 15; i++)
         applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp, 1'b0, 1'b1,
                       $sformatf("vec%0d", i));
      applyIdle(1'b0);
      checkOutput("halt after strobe-less write", halt, 0);
      for (int i = 0; i < 3; i++) applyIdle(1'b0);

      $display("[TB] mtime write then back-to-back reads");
      applyStimulus(16'h0000, 32'h00000010, 4'b1111, 32'h0, 1'b0, 1'b1, "mtime write");
      applyStimulus(16'h0000, 32'h0, 4'd0, 32'h00000011, 1'b0, 1'b1, "mtime read 1");
      applyStimulus(16'h0000, 32'h0, 4'd0, 32'h00000012, 1'b0, 1'b1, "mtime read 2");
      for (int i = 0; i < 4; i++) applyIdle(1'b0);

      $display("[TB] timer interrupt");
      applyStimulus(16'h000C, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b1, "cmp hi");
      applyStimulus(16'h0000, 32'h00000100, 4'b1111, 32'h0, 1'b0, 1'b1, "mtime lo");
      a_cyc = cyc;
      applyStimulus(16'h0008, 32'h00000108, 4'b1111, 32'h0, 1'b0, 1'b1, "cmp lo");
      for (int i = 0; i < 13; i++) begin
         applyIdle(1'b0);
         checkOutput($sformatf("timer_irq at +%0d", cyc - a_cyc), timer_irq,
                     (cyc >= a_cyc + 9) ? 64'd1 : 64'd0);
      end
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000005, 1'b0, 1'b1, "status irq");
      for (int i = 0; i < 3; i++) applyIdle(1'b0);

      $display("[TB] TX overflow and drain");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(16'h0010, 32'h41 + i, 4'b0001, 32'h0, 1'b0, 1'b1, "tx push");
         if (i < 8) txq.push_back(8'(8'h41 + i));
      end
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h0000001B, 1'b0, 1'b1, "status full ovf");
      for (int i = 0; i < 12; i++) applyIdle(1'b1);
      checkOutput("tx queue drained", txq.size(), 0);
      checkOutput("tx_valid after drain", tx_valid, 0);
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000015, 1'b1, 1'b1, "status empty ovf");
      applyStimulus(16'h0014, 32'h00000010, 4'b0001, 32'h0, 1'b1, 1'b1, "ovf clear");
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000005, 1'b1, 1'b1, "status ovf cleared");
      for (int i = 0; i < 3; i++) applyIdle(1'b0);

      $display("[TB] push into full FIFO with simultaneous pop");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(16'h0010, 32'h50 + i, 4'b0001, 32'h0, (i == 8) ? 1'b1 : 1'b0, 1'b1, "tx push");
         txq.push_back(8'(8'h50 + i));
      end
      for (int i = 0; i < 12; i++) applyIdle(1'b1);
      checkOutput("tx queue drained 2", txq.size(), 0);
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000005, 1'b1, 1'b1, "status no ovf");
      for (int i = 0; i < 3; i++) applyIdle(1'b0);

      $display("[TB] halt");
      applyStimulus(16'h0018, 32'h000000A5, 4'b0001, 32'h0, 1'b0, 1'b1, "halt a5");
      applyStimulus(16'h0018, 32'h0000003C, 4'b1111, 32'h0, 1'b0, 1'b1, "halt 3c");
      applyIdle(1'b0);
      checkOutput("halt set", halt, 1);
      checkOutput("halt_code first", halt_code, 8'hA5);

      $display("[TB] reset discards in-flight read");
      rv_before = rv_seen;
      applyStimulus(16'h0008, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, "pre-reset read");
      @(posedge clk); #1;
      valid = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(16'h0014, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0, "in reset");
      checkResetOutputs("reset2");
      applyIdle(1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) applyIdle(1'b0);
      checkOutput("no stale rvalid", rv_seen - rv_before, 0);

      applyStimulus(16'h0008, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 1'b1, "cmp byte1");
      applyStimulus(16'h0008, 32'h0, 4'd0, 32'hFFFFABFF, 1'b0, 1'b1, "cmp lo byte1");
      applyStimulus(16'h000C, 32'h0, 4'd0, 32'hFFFFFFFF, 1'b0, 1'b1, "cmp hi untouched");
      applyStimulus(16'h0014, 32'h0, 4'd0, 32'h00000004, 1'b0, 1'b1, "status after reset2");
      applyIdle(1'b0);

      for (int i = 0; i < 20; i++) begin
         if (sbq.size() == 0) break;
         applyIdle(1'b0);
      end
      checkOutput("scoreboard drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mrv32_mmio.md
MRV32_MMIO -- requirements
Module: mrv32_mmio

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, default 16, request address width.
REQ-002 SHALL have parameter: RD_LATENCY, default 2, request-to-rvalid cycles for reads, legal range 1..8.
REQ-003 SHALL have parameter: FIFO_DEPTH, default 8, TX FIFO entries, power of two, at least 2.
REQ-004 SHALL have port: clk  input  1  clock; all logic rises on posedge.
REQ-005 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port: valid  input  1  single-cycle request strobe from the core data port.
REQ-007 SHALL have port: addr  input  ADDR_WIDTH  byte address; only addr[4:2] is decoded, other bits are ignored.
REQ-008 SHALL have port: wdata  input  32  write data.
REQ-009 SHALL have port: wstrb  input  4  byte enables; nonzero means write, zero means read.
REQ-010 SHALL have port: rdata  output  32  read data, meaningful only while rvalid=1.
REQ-011 SHALL have port: rvalid  output  1  one-cycle read response.
REQ-012 SHALL have port: timer_irq  output  1  high when mtime >= mtimecmp (unsigned 64-bit).
REQ-013 SHALL have ports: tx_valid  output  1; tx_data  output  8; tx_ready  input  1 (console byte stream).
REQ-014 SHALL have ports: halt  output  1  sticky; halt_code  output  8.

Function
REQ-015 SHALL decode this register map on addr[4:2]:
- 0 MTIME_LO, RW
- 1 MTIME_HI, RW
- 2 MTIMECMP_LO, RW
- 3 MTIMECMP_HI, RW
- 4 TX_DATA: W pushes wdata[7:0]; R returns 0
- 5 STATUS: R {27'b0, ovf, full, empty, count-nonzero, irq}; W1C on bit 4 (ovf)
- 6 HALT, W only
- 7 unmapped
REQ-016 SHALL apply wstrb per byte on RW registers; unstrobed bytes keep their value.
REQ-017 SHALL ignore writes to unmapped or read-only locations, and SHALL return 0 for reads of them.
REQ-018 SHALL respond to writes with no rvalid; a write completes in its request cycle.
REQ-019 SHALL sample read data in the request cycle and drive it out exactly RD_LATENCY cycles later, with rvalid=1 for one cycle.
REQ-020 SHALL implement the read path as a RD_LATENCY-deep pipeline accepting one request every cycle, so back-to-back reads return in order on consecutive cycles.
REQ-021 SHALL increment mtime by 1 every cycle, wrapping 2^64-1 to 0.
REQ-022 SHALL give a software write to MTIME_LO/HI priority over the increment in the same cycle; bytes not written take the incremented value.
REQ-023 SHALL drive timer_irq combinationally from the registered mtime and mtimecmp.
REQ-024 TX FIFO SHALL push on a write to TX_DATA with wstrb[0]=1 when not full, or when full with a pop in the same cycle.
REQ-025 TX FIFO SHALL pop when tx_valid && tx_ready; tx_valid = !empty, and tx_data = head entry.
REQ-026 SHALL drop a push to a full FIFO with no same-cycle pop, and SHALL set sticky ovf.
REQ-027 ovf SHALL clear on a STATUS write with wstrb[0] && wdata[4]; if an overflow occurs in the same cycle, set wins.
REQ-028 SHALL set halt=1 and halt_code=wdata[7:0] on the first write to HALT with wstrb[0]=1; later HALT writes SHALL be ignored until reset.
REQ-029 SHALL use wrap-around read/write pointers plus a count register (0..FIFO_DEPTH).

Reset
REQ-030 While rst_n=0, SHALL hold: rvalid=0, rdata=0, mtime=0, mtimecmp=all ones, timer_irq=0, FIFO empty, tx_valid=0, tx_data=0, ovf=0, halt=0, halt_code=0.
REQ-031 SHALL discard in-flight read responses when reset is asserted; no rvalid appears after reset release for requests issued before it.
REQ-032 SHALL ignore requests presented while rst_n=0.

Verification
REQ-033 Setup RD_LATENCY=2: read STATUS at cycle N after reset -> rvalid at N+2 only, rdata=0x00000004 (empty).
REQ-034 Write MTIME_LO=0x10 at cycle N; read MTIME_LO at N+1 -> returned value 0x11; back-to-back reads at N+1 and N+2 -> rvalid at N+3 and N+4.
REQ-035 Write MTIMECMP_HI=0, then MTIMECMP_LO=mtime+5 -> timer_irq rises exactly when mtime reaches that value and stays high.
REQ-036 tx_ready=0; write 9 bytes 0x41..0x49 with FIFO_DEPTH=8 -> STATUS full=1, ovf=1; then tx_ready=1 -> stream 0x41..0x48 in order, then empty; write STATUS 0x10 -> ovf=0.
REQ-037 Write HALT 0xA5, then HALT 0x3C -> halt=1, halt_code=0xA5.
REQ-038 Read issued at cycle N, rst_n=0 at N+1 -> no rvalid; write wstrb=4'b0010 to MTIMECMP_LO (wdata 0x0000AB00) -> only byte 1 changes.
